// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response channel bundle for the iterative mul/div unit
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide unit, one operand bit per cycle
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [2:0]      r_op;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;      // product low half + multiplier / quotient + dividend
  logic [XLEN-1:0] r_opnd;    // |a| as multiplicand, or |b| as divisor
  logic [XLEN-1:0] r_resp_data;

  logic            w_req_ready;
  logic            w_resp_valid;
  logic            w_busy;
  logic            w_accept;

  // operand decode at accept time
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic            w_neg_res;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_data;

  // iteration datapath
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_sh;
  logic            w_div_ge;
  logic [XLEN-1:0] w_div_diff;

  // sign fix-up datapath
  logic [2*XLEN-1:0] w_prod_n;
  logic [XLEN-1:0]   w_dq;
  logic [XLEN-1:0]   w_dq_n;
  logic [XLEN-1:0]   w_fix_result;

  assign w_accept = bus.req_valid & w_req_ready & ~bus.kill;

  assign w_a_signed = (bus.req_op == 3'd0) || (bus.req_op == 3'd1) || (bus.req_op == 3'd2) ||
                      (bus.req_op == 3'd4) || (bus.req_op == 3'd6);
  assign w_b_signed = (bus.req_op == 3'd0) || (bus.req_op == 3'd1) ||
                      (bus.req_op == 3'd4) || (bus.req_op == 3'd6);
  assign w_neg_a    = w_a_signed & bus.req_a[XLEN-1];
  assign w_neg_b    = w_b_signed & bus.req_b[XLEN-1];
  // remainder follows the dividend sign; everything else follows sign(a)^sign(b)
  assign w_neg_res  = (bus.req_op[2] && bus.req_op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
  assign w_a_abs    = w_neg_a ? -bus.req_a : bus.req_a;
  assign w_b_abs    = w_neg_b ? -bus.req_b : bus.req_b;

  assign w_b_zero   = (bus.req_b == '0);
  assign w_ovf      = ((bus.req_op == 3'd4) || (bus.req_op == 3'd6)) &&
                      (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
  assign w_special  = bus.req_op[2] & (w_b_zero | w_ovf);
  assign w_special_data = w_b_zero ? (bus.req_op[1] ? bus.req_a : '1)
                                   : (bus.req_op[1] ? '0 : bus.req_a);

  assign w_mul_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {XLEN{1'b0}})};
  assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
  assign w_div_diff = w_div_sh[XLEN-1:0] - r_opnd;

  assign w_prod_n   = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_dq       = r_op[1] ? r_hi : r_lo;
  assign w_dq_n     = r_neg ? -w_dq : w_dq;
  assign w_fix_result = r_op[2] ? w_dq_n :
                        (r_op == 3'd0) ? w_prod_n[XLEN-1:0] : w_prod_n[2*XLEN-1:XLEN];

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state selection; kill overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.kill) w_next = S_IDLE;
  end

  // handshake outputs decoded from state
  always_comb begin
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: w_req_ready  = rst_n;
      S_CALC: w_busy       = 1'b1;
      S_FIX:  w_busy       = 1'b1;
      S_DONE: begin
        w_busy       = 1'b1;
        w_resp_valid = 1'b1;
      end
      default: w_req_ready = 1'b0;
    endcase
  end

  // operand latch, shift-add / restoring-divide step, and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_resp_data <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_op   <= bus.req_op;
        r_neg  <= w_neg_res;
        r_cnt  <= CW'(XLEN);
        r_hi   <= '0;
        if (bus.req_op[2]) begin
          r_lo   <= w_a_abs;
          r_opnd <= w_b_abs;
        end else begin
          r_lo   <= w_b_abs;
          r_opnd <= w_a_abs;
        end
        if (w_special) r_resp_data <= w_special_data;
      end
    end else if (r_state == S_CALC && !bus.kill) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op[2]) begin
        r_hi <= w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (r_state == S_FIX && !bus.kill) begin
      r_resp_data <= w_fix_result;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed vector bench for muldiv_seq
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // edges after the accept edge until resp_valid is visible
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // called at posedge+1 with the unit idle; returns once resp_valid is seen or a bound expires
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int lat);
    check("req_ready_before_req", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus.resp_data;
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_valid_after_take", {31'd0, bus.resp_valid}, 32'd0);
    check("req_ready_after_take", {31'd0, bus.req_ready}, 32'd1);
  endtask

  vec_t        vecs[15];
  logic [31:0] data;
  int          lat;
  int          seen;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"mul_7_m3",       3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"mulh_min_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"mulhsu_m1_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[3]  = '{"mulhu_max_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[4]  = '{"mulhu_small",    3'd3, 32'h12345678, 32'h00000010, 32'h00000001, 33};
    vecs[5]  = '{"div_m7_2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[6]  = '{"rem_m7_2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[7]  = '{"divu_100_7",     3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[8]  = '{"remu_100_7",     3'd7, 32'd100,      32'd7,        32'd2,        33};
    vecs[9]  = '{"div_100_m7",     3'd4, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[10] = '{"rem_100_m7",     3'd6, 32'd100,      32'hFFFFFFF9, 32'd2,        33};
    vecs[11] = '{"div_5_0",        3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[12] = '{"remu_5_0",       3'd7, 32'd5,        32'd0,        32'd5,        0};
    vecs[13] = '{"div_ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[14] = '{"rem_ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};

    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    check("rst_resp_data",  bus.resp_data,           32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // vector table
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, lat);
      check({vecs[i].name, "_data"}, data, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      take_resp();
    end

    // response back-pressure: DONE holds for 5 cycles with resp_ready low
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hold_resp_data",  bus.resp_data,           32'hFFFFFFFE);
      check("hold_req_ready",  {31'd0, bus.req_ready},  32'd0);
    end
    take_resp();

    // kill in CALC cycle 10
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'h00001234;
    bus.req_b     = 32'h00005678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_kill_busy", {31'd0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill_busy",       {31'd0, bus.busy},       32'd0);
    check("kill_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("kill_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("kill_resp_data",  bus.resp_data,           32'hFFFFFFFE);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    check("kill_no_resp", seen, 0);
    run_op(3'd0, 32'd3, 32'd4, data, lat);
    check("mul_3_4_data", data, 32'd12);
    check("mul_3_4_lat",  lat,  33);
    take_resp();

    // kill in IDLE blocks a concurrent request
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd0;
    bus.kill      = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    check("idle_kill_busy",       {31'd0, bus.busy},       32'd0);
    check("idle_kill_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("idle_kill_resp_data",  bus.resp_data,           32'd12);

    // reset mid-CALC
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    bus.req_a     = 32'd1000;
    bus.req_b     = 32'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_req_ready",  {31'd0, bus.req_ready},  32'd0);
    check("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("midrst_busy",       {31'd0, bus.busy},       32'd0);
    check("midrst_resp_data",  bus.resp_data,           32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd5, 32'd1000, 32'd3, data, lat);
    check("divu_after_rst_data", data, 32'd333);
    check("divu_after_rst_lat",  lat,  33);
    take_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
